// File: rtl/btn_sched_pkg.sv
// Shared definitions for the button command scheduler: FSM encoding and lockout counter width.
package btn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_LOCKOUT = 2'b10
    } sched_state_e;

    localparam int LOCK_CNT_W = 20;

endpackage

// File: rtl/btn_rr_pick.sv
// Combinational rotating-priority picker: grants the first set request at or above i_PTR, with wrap.
module btn_rr_pick #(
    parameter  int N_BTN = 4,
    localparam int IDW   = $clog2(N_BTN)
) (
    input  logic [N_BTN-1:0] i_REQ,
    input  logic [IDW-1:0]   i_PTR,
    output logic [IDW-1:0]   o_GRANT,
    output logic             o_ANY
);

    int w_idx;

    always_comb begin
        o_GRANT = '0;
        o_ANY   = 1'b0;
        w_idx   = 0;
        // Scan farthest-first so the request nearest the pointer overwrites the rest.
        for (int i = N_BTN - 1; i >= 0; i--) begin
            w_idx = int'(i_PTR) + i;
            if (w_idx >= N_BTN) w_idx = w_idx - N_BTN;
            if (i_REQ[w_idx[IDW-1:0]]) begin
                o_GRANT = w_idx[IDW-1:0];
                o_ANY   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_cmd_scheduler.sv
// Latches button ticks as pending requests and issues them round-robin with a post-accept lockout.
// Define BTN_SCHED_OVERRUN_CNT_EN to add the saturating dropped-tick counter o_OVERRUN_CNT.
module button_cmd_scheduler
    import btn_sched_pkg::*;
#(
    parameter  int N_BTN          = 4,
    parameter  int LOCKOUT_CYCLES = 1000,
    localparam int IDW            = $clog2(N_BTN)
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [N_BTN-1:0] i_TICK,
    output logic             o_CMD_VALID,
    input  logic             i_CMD_READY,
    output logic [IDW-1:0]   o_CMD_ID,
    output logic [N_BTN-1:0] o_PENDING,
    output logic             o_BUSY
`ifdef BTN_SCHED_OVERRUN_CNT_EN
   ,output logic [7:0]       o_OVERRUN_CNT
`endif
);

    sched_state_e          r_state, w_state_nxt;
    logic [N_BTN-1:0]      r_pending, w_clear;
    logic [IDW-1:0]        r_ptr, r_cmd_id, w_grant, w_ptr_nxt;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic                  r_valid, r_busy, w_any, w_take, w_accept;

    btn_rr_pick #(.N_BTN(N_BTN)) u_pick (
        .i_REQ   (r_pending),
        .i_PTR   (r_ptr),
        .o_GRANT (w_grant),
        .o_ANY   (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_any) begin
                w_take      = 1'b1;
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: if (i_CMD_READY) begin
                w_accept    = 1'b1;
                w_state_nxt = (LOCKOUT_CYCLES == 0) ? ST_IDLE : ST_LOCKOUT;
            end
            ST_LOCKOUT: if (r_lock_cnt == LOCK_CNT_W'(1)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clear = '0;
        for (int k = 0; k < N_BTN; k++) w_clear[k] = w_take && (w_grant == IDW'(k));
    end

    assign w_ptr_nxt = (w_grant == IDW'(N_BTN - 1)) ? '0 : w_grant + IDW'(1);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_pending  <= '0;
            r_ptr      <= '0;
            r_cmd_id   <= '0;
            r_valid    <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            // A tick on the grant edge re-arms the bit as a fresh request.
            r_pending <= (r_pending & ~w_clear) | i_TICK;
            if (w_take) begin
                r_cmd_id <= w_grant;
                r_valid  <= 1'b1;
                r_ptr    <= w_ptr_nxt;
            end
            if (w_accept) begin
                r_valid    <= 1'b0;
                r_lock_cnt <= LOCK_CNT_W'(LOCKOUT_CYCLES);
            end else if (r_state == ST_LOCKOUT) begin
                r_lock_cnt <= r_lock_cnt - LOCK_CNT_W'(1);
            end
        end
    end

    assign o_CMD_VALID = r_valid;
    assign o_CMD_ID    = r_cmd_id;
    assign o_PENDING   = r_pending;
    assign o_BUSY      = r_busy;

`ifdef BTN_SCHED_OVERRUN_CNT_EN
    logic [N_BTN-1:0] w_overrun;
    logic [8:0]       w_ovr_sum;
    logic [7:0]       r_ovr_cnt;

    assign w_overrun = i_TICK & r_pending & ~w_clear;

    always_comb begin
        w_ovr_sum = {1'b0, r_ovr_cnt};
        for (int k = 0; k < N_BTN; k++) if (w_overrun[k]) w_ovr_sum = w_ovr_sum + 9'd1;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) r_ovr_cnt <= '0;
        else       r_ovr_cnt <= (w_ovr_sum > 9'd255) ? 8'hFF : w_ovr_sum[7:0];
    end

    assign o_OVERRUN_CNT = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler: dut_a uses a 2-cycle lockout, dut_b a 5-cycle lockout.
module tb_button_cmd_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, rdy;
    logic [N-1:0] tick;
    logic         a_vld, b_vld, a_busy, b_busy;
    logic [1:0]   a_id, b_id;
    logic [N-1:0] a_pend, b_pend;
`ifdef BTN_SCHED_OVERRUN_CNT_EN
    logic [7:0]   a_ovr, b_ovr;
`endif
    int total = 0;
    int bad   = 0;
    int extra;

    always #5 clk = ~clk;

    button_cmd_scheduler #(.N_BTN(N), .LOCKOUT_CYCLES(2)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_TICK(tick), .o_CMD_VALID(a_vld), .i_CMD_READY(rdy),
        .o_CMD_ID(a_id), .o_PENDING(a_pend), .o_BUSY(a_busy)
`ifdef BTN_SCHED_OVERRUN_CNT_EN
       ,.o_OVERRUN_CNT(a_ovr)
`endif
    );

    button_cmd_scheduler #(.N_BTN(N), .LOCKOUT_CYCLES(5)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_TICK(tick), .o_CMD_VALID(b_vld), .i_CMD_READY(rdy),
        .o_CMD_ID(b_id), .o_PENDING(b_pend), .o_BUSY(b_busy)
`ifdef BTN_SCHED_OVERRUN_CNT_EN
       ,.o_OVERRUN_CNT(b_ovr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst  = 1'b1;
        tick = '0;
        rdy  = 1'b0;
        step();
        rst  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; tick = '0; rdy = 1'b0;
        repeat (3) step();
        chk("rst_vld",  32'(a_vld),  0);
        chk("rst_id",   32'(a_id),   0);
        chk("rst_pend", 32'(a_pend), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_bvld", 32'(b_vld),  0);
`ifdef BTN_SCHED_OVERRUN_CNT_EN
        chk("rst_ovr",  32'(a_ovr),  0);
`endif
        rst = 1'b0;

        // single request then backpressure
        tick = 4'b0100;
        step();
        tick = '0;
        chk("one_pend", 32'(a_pend), 4'b0100);
        chk("one_vld0", 32'(a_vld),  0);
        step();
        chk("one_vld",  32'(a_vld),  1);
        chk("one_id",   32'(a_id),   2);
        chk("one_clr",  32'(a_pend), 0);
        chk("one_busy", 32'(a_busy), 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_vld", 32'(a_vld), 1);
            chk("bp_id",  32'(a_id),  2);
        end
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("bp_drop", 32'(a_vld),  0);
        chk("bp_lk",   32'(a_busy), 1);
        step();
        chk("bp_lk2",  32'(a_busy), 1);
        step();
        chk("bp_idle", 32'(a_busy), 0);

        // round-robin, L=2, ready held high
        rst_pulse();
        rdy  = 1'b1;
        tick = 4'b1111;
        step();
        tick = '0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("rr_vld", 32'(a_vld), (k % 4 == 1) ? 1 : 0);
            if (k % 4 == 1) chk("rr_id", 32'(a_id), (k - 1) / 4);
        end
        tick = 4'b0011;
        step();
        tick = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("wrap_vld", 32'(a_vld), (k % 4 == 1) ? 1 : 0);
            if (k % 4 == 1) chk("wrap_id", 32'(a_id), (k - 1) / 4);
        end

        // lockout, L=5 on dut_b
        rst_pulse();
        rdy  = 1'b1;
        tick = 4'b0001;
        step();
        tick = '0;
        step();
        chk("lk_vld", 32'(b_vld), 1);
        chk("lk_id",  32'(b_id),  0);
        step();
        chk("lk_acc", 32'(b_vld),  0);
        chk("lk_b0",  32'(b_busy), 1);
        tick = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            step();
            tick = '0;
            chk("lk_busy", 32'(b_busy), (k <= 4 || k == 6) ? 1 : 0);
            chk("lk_nvld", 32'(b_vld),  (k == 6) ? 1 : 0);
        end
        chk("lk_id1", 32'(b_id), 1);

        // tick coincident with its own grant edge re-arms the request
        rst_pulse();
        tick = 4'b0001;
        step();
        step();
        tick = '0;
        chk("co_vld",  32'(a_vld),  1);
        chk("co_id",   32'(a_id),   0);
        chk("co_pend", 32'(a_pend), 4'b0001);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("co_acc", 32'(a_vld), 0);
        repeat (3) step();
        chk("co_vld2", 32'(a_vld),  1);
        chk("co_id2",  32'(a_id),   0);
        chk("co_clr",  32'(a_pend), 0);
`ifdef BTN_SCHED_OVERRUN_CNT_EN
        chk("co_ovr",  32'(a_ovr),  0);
`endif

        // overrun: button 0 ticked twice while button 3 is in ISSUE
        rst_pulse();
        tick = 4'b1000;
        step();
        tick = '0;
        step();
        chk("ov_id3", 32'(a_id), 3);
        tick = 4'b0001;
        step();
        tick = '0;
        step();
        tick = 4'b0001;
        step();
        tick = '0;
        chk("ov_pend", 32'(a_pend), 4'b0001);
`ifdef BTN_SCHED_OVERRUN_CNT_EN
        chk("ov_cnt",  32'(a_ovr),  1);
`endif
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        repeat (3) step();
        chk("ov_vld", 32'(a_vld), 1);
        chk("ov_id0", 32'(a_id),  0);
        rdy   = 1'b1;
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (a_vld) extra++;
        end
        chk("ov_once", 32'(extra), 0);

        // asynchronous reset during ISSUE
        rst_pulse();
        tick = 4'b0100;
        step();
        tick = 4'b0010;
        step();
        tick = '0;
        chk("ri_vld",  32'(a_vld),  1);
        chk("ri_pend", 32'(a_pend), 4'b0010);
        rst = 1'b1;
        #2;
        chk("ri_avld",  32'(a_vld),  0);
        chk("ri_abusy", 32'(a_busy), 0);
        chk("ri_apend", 32'(a_pend), 0);
        step();
        rst  = 1'b0;
        tick = 4'b1001;
        step();
        tick = '0;
        step();
        chk("ri_vld2", 32'(a_vld), 1);
        chk("ri_id0",  32'(a_id),  0);

        // asynchronous reset during LOCKOUT
        rdy = 1'b1;
        step();
        rdy  = 1'b0;
        tick = 4'b0100;
        chk("rl_busy", 32'(a_busy), 1);
        step();
        tick = '0;
        chk("rl_busy2", 32'(a_busy), 1);
        chk("rl_pend",  32'(a_pend), 4'b1100);
        rst = 1'b1;
        #2;
        chk("rl_avld",  32'(a_vld),  0);
        chk("rl_abusy", 32'(a_busy), 0);
        chk("rl_apend", 32'(a_pend), 0);
        step();
        rst  = 1'b0;
        tick = 4'b1001;
        step();
        tick = '0;
        step();
        chk("rl_vld2", 32'(a_vld), 1);
        chk("rl_id0",  32'(a_id),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
